// File: rtl/buffer_stream_pkg.sv
// Shared types and helpers for the buffer stream reader.
// Optional checksum unit is enabled with READER_CSUM_EN.
package buffer_stream_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int BYTES_PER_WORD     = DATA_WIDTH_DEFAULT / 8;
  localparam int BYTE_CNT_W         = $clog2(BYTES_PER_WORD) + 1;

  // Ones'-complement add; the folded result cannot carry out a second time.
  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/buffer_stream_reader_csum.sv
// Pair-and-accumulate 16-bit ones'-complement sum over a byte stream.
// Instantiated by buffer_stream_reader only when READER_CSUM_EN is defined.
module ones_comp_sum16
  import buffer_stream_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [15:0] csum
);

  logic [15:0] acc;
  logic [7:0]  hi_byte;
  logic        odd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      hi_byte <= '0;
      odd     <= 1'b0;
    end else if (clear) begin
      acc     <= '0;
      hi_byte <= '0;
      odd     <= 1'b0;
    end else if (byte_valid) begin
      if (!odd) begin
        hi_byte <= byte_in;
        odd     <= 1'b1;
      end else begin
        acc <= ones_add16(acc, {hi_byte, byte_in});
        odd <= 1'b0;
      end
    end
  end

  // A pending odd byte is folded in zero-padded so csum is final without an extra cycle.
  assign csum = odd ? ones_add16(acc, {hi_byte, 8'h00}) : acc;

endmodule

// File: rtl/buffer_stream_reader.sv
// Drains a word buffer and serialises len bytes MSB-first onto an 8-bit valid/ready stream.
// Define READER_CSUM_EN to add the csum output and ones'-complement accumulator.
module buffer_stream_reader
  import buffer_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] buf_data_out,
  input  logic                  buf_data_av,
  output logic                  buf_rd_en,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done
`ifdef READER_CSUM_EN
  ,
  output logic [15:0]           csum
`endif
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(BPW) + 1;

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [CNT_W-1:0]      word_bytes;
  logic [DATA_WIDTH-1:0] shreg;

  assign buf_rd_en = (state == S_FETCH) && buf_data_av;
  assign tx_data   = shreg[DATA_WIDTH-1 -: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      remaining  <= '0;
      word_bytes <= '0;
      shreg      <= '0;
      tx_valid   <= 1'b0;
      tx_last    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state    <= S_IDLE;
        tx_valid <= 1'b0;
        tx_last  <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              busy <= 1'b1;
              if (len != '0) begin
                remaining <= len;
                state     <= S_FETCH;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            if (buf_data_av) state <= S_WAIT;
          end
          S_WAIT: begin
            shreg      <= buf_data_out;
            word_bytes <= CNT_W'(BPW);
            tx_valid   <= 1'b1;
            tx_last    <= (remaining == LEN_WIDTH'(1));
            state      <= S_SHIFT;
          end
          S_SHIFT: begin
            if (tx_ready) begin
              shreg      <= shreg << 8;
              remaining  <= remaining - LEN_WIDTH'(1);
              word_bytes <= word_bytes - CNT_W'(1);
              // tx_last is registered, so it looks one byte ahead of the decrement.
              if (remaining == LEN_WIDTH'(1)) begin
                state    <= S_DONE;
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
                done     <= 1'b1;
              end else if (word_bytes == CNT_W'(1)) begin
                state    <= S_FETCH;
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
              end else begin
                tx_last <= (remaining == LEN_WIDTH'(2));
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef READER_CSUM_EN
  logic tx_fire;
  logic csum_clear;
  assign tx_fire    = (state == S_SHIFT) && tx_ready && !abort;
  assign csum_clear = (state == S_IDLE) && start;

  ones_comp_sum16 u_csum (
    .clk        (clk),
    .reset      (reset),
    .clear      (csum_clear),
    .byte_valid (tx_fire),
    .byte_in    (tx_data),
    .csum       (csum)
  );
`endif

endmodule

// File: tb/tb_buffer_stream_reader.sv
// Randomised self-checking bench for buffer_stream_reader with a word-queue buffer model.
// Checksum checks are included when READER_CSUM_EN is defined.
module tb_buffer_stream_reader;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset, start, abort, tx_ready, av_en;
  logic [LW-1:0] len;
  logic [DW-1:0] buf_data_out = '0;
  logic          buf_data_av, buf_rd_en, tx_valid, tx_last, busy, done;
  logic [7:0]    tx_data;
`ifdef READER_CSUM_EN
  logic [15:0]   csum;
`endif

  int checks = 0;
  int errors = 0;

  buffer_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .len          (len),
    .abort        (abort),
    .buf_data_out (buf_data_out),
    .buf_data_av  (buf_data_av),
    .buf_rd_en    (buf_rd_en),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_last      (tx_last),
    .busy         (busy),
    .done         (done)
`ifdef READER_CSUM_EN
    ,
    .csum         (csum)
`endif
  );

  always #5 clk = ~clk;

  // Buffer model: circular word store, data appears the cycle after a sampled pop.
  logic [31:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign buf_data_av = av_en && (rd_ptr != wr_ptr);

  always @(posedge clk) begin
    if (buf_rd_en && rd_ptr != wr_ptr) begin
      buf_data_out <= mem[rd_ptr % 1024];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor, sampled mid-cycle.
  logic [7:0] got_q [$];
  bit         last_q [$];
  int pops, dones, done_cyc, last_hs_cyc, first_rd_cyc, first_v_cyc, proto_err;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last))
        proto_err++;
      if (buf_rd_en && !buf_data_av) proto_err++;
      if (buf_rd_en) begin
        pops++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (tx_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (tx_valid && tx_ready && !abort) begin
        got_q.push_back(tx_data);
        last_q.push_back(tx_last);
        last_hs_cyc = cyc;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      prev_hold = tx_valid && !tx_ready && !abort;
      prev_data = tx_data;
      prev_last = tx_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    pops = 0; dones = 0; done_cyc = -1; last_hs_cyc = -1;
    first_rd_cyc = -1; first_v_cyc = -1; proto_err = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr++;
  endtask

  function automatic logic [7:0] ref_byte(input int base, input int idx);
    logic [31:0] w;
    w = mem[(base + idx / 4) % 1024];
    return 8'(w >> (24 - 8 * (idx % 4)));
  endfunction

  function automatic logic [15:0] ref_csum(input int base, input int n);
    int s = 0;
    for (int i = 0; i < n; i += 2) begin
      s += int'(ref_byte(base, i)) * 256;
      if (i + 1 < n) s += int'(ref_byte(base, i + 1));
    end
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  // Issues start and waits (bounded) for the block to return to idle.
  task automatic run_packet(input int n, input int rmode, input bit rand_av,
                            input int budget, output bit timed_out);
    start    = 1'b1;
    len      = LW'(n);
    tx_ready = ready_for(rmode, 0);
    tick();
    start     = 1'b0;
    timed_out = 1'b1;
    for (int k = 1; k < budget; k++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      tx_ready = ready_for(rmode, k);
      if (rand_av) av_en = $urandom_range(0, 3) != 0;
      tick();
    end
    av_en    = 1'b1;
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0; av_en = 1'b1; len = '0;
    repeat (3) tick();
    outs = {buf_rd_en, tx_valid, tx_last, busy, done, tx_data};
    checks++;
    if (outs !== 13'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    reset = 1'b0;
    tick();
    outs = {buf_rd_en, tx_valid, tx_last, busy, done, tx_data};
    checks++;
    if (outs !== 13'h0) begin
      errors++; $display("FAIL idle_after_reset: got %h expected 0", outs);
    end
  endtask

  task automatic test_basic_len6();
    logic [7:0] exp_b [6];
    bit to;
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    push_word(32'hAABBCCDD);
    push_word(32'h11223344);
    clear_mon();
    run_packet(6, 0, 1'b0, 100, to);
    checks++;
    if (to) begin errors++; $display("FAIL len6_timeout: got busy expected idle"); end
    checks++;
    if (got_q.size() !== 6) begin
      errors++; $display("FAIL len6_count: got %0d expected 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_q[i] !== exp_b[i]) begin
          errors++; $display("FAIL len6_byte%0d: got %h expected %h", i, got_q[i], exp_b[i]);
        end
      end
      checks++;
      if ({last_q[0], last_q[1], last_q[2], last_q[3], last_q[4], last_q[5]} !== 6'b000001) begin
        errors++; $display("FAIL len6_last: got %b%b%b%b%b%b expected 000001",
                           last_q[0], last_q[1], last_q[2], last_q[3], last_q[4], last_q[5]);
      end
    end
    checks++;
    if (pops !== 2) begin errors++; $display("FAIL len6_pops: got %0d expected 2", pops); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL len6_dones: got %0d expected 1", dones); end
    checks++;
    if (done_cyc !== last_hs_cyc + 1) begin
      errors++; $display("FAIL len6_done_timing: got %0d expected %0d", done_cyc, last_hs_cyc + 1);
    end
`ifdef READER_CSUM_EN
    checks++;
    if (csum !== 16'h88BB) begin errors++; $display("FAIL len6_csum: got %h expected 88bb", csum); end
`endif
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [4];
    bit to;
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_word(32'hAABBCCDD);
    clear_mon();
    run_packet(4, 1, 1'b0, 200, to);
    checks++;
    if (to || got_q.size() !== 4) begin
      errors++; $display("FAIL bp_count: got %0d expected 4 (timeout=%0d)", got_q.size(), to);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== exp_b[i] || last_q[i] !== (i == 3)) begin
          errors++; $display("FAIL bp_byte%0d: got %h/%0d expected %h/%0d",
                             i, got_q[i], last_q[i], exp_b[i], i == 3);
        end
      end
    end
    checks++;
    if (proto_err !== 0) begin errors++; $display("FAIL bp_hold: got %0d violations expected 0", proto_err); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL bp_dones: got %0d expected 1", dones); end
  endtask

  task automatic test_latency();
    int n0;
    bit to;
    push_word($urandom);
    clear_mon();
    n0 = cyc;
    run_packet(1, 0, 1'b0, 50, to);
    checks++;
    if (first_rd_cyc !== n0 + 1) begin
      errors++; $display("FAIL lat_rd_en: got cycle %0d expected %0d", first_rd_cyc, n0 + 1);
    end
    checks++;
    if (first_v_cyc !== n0 + 3) begin
      errors++; $display("FAIL lat_valid: got cycle %0d expected %0d", first_v_cyc, n0 + 3);
    end
  endtask

  task automatic test_av_stall();
    int base;
    bit to;
    push_word($urandom);
    base = rd_ptr;
    clear_mon();
    av_en    = 1'b0;
    tx_ready = 1'b1;
    start    = 1'b1;
    len      = LW'(4);
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if (pops !== 0 || busy !== 1'b1) begin
      errors++; $display("FAIL stall_no_pop: got pops=%0d busy=%0d expected 0/1", pops, busy);
    end
    av_en = 1'b1;
    to = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (!busy) begin to = 1'b0; break; end
      tick();
    end
    checks++;
    if (to || first_v_cyc - first_rd_cyc !== 2) begin
      errors++; $display("FAIL stall_pop_to_valid: got %0d expected 2 (timeout=%0d)",
                         first_v_cyc - first_rd_cyc, to);
    end
    checks++;
    if (got_q.size() !== 4 || got_q[0] !== ref_byte(base, 0) || got_q[3] !== ref_byte(base, 3)) begin
      errors++; $display("FAIL stall_bytes: got %0d bytes expected 4 matching", got_q.size());
    end
  endtask

  task automatic test_len0();
    int n0;
    bit to;
    clear_mon();
    n0 = cyc;
    run_packet(0, 0, 1'b0, 20, to);
    repeat (2) tick();
    checks++;
    if (to || dones !== 1 || done_cyc !== n0 + 1) begin
      errors++; $display("FAIL len0_done: got dones=%0d at %0d expected 1 at %0d", dones, done_cyc, n0 + 1);
    end
    checks++;
    if (pops !== 0 || first_v_cyc !== -1) begin
      errors++; $display("FAIL len0_quiet: got pops=%0d valid_cyc=%0d expected 0/-1", pops, first_v_cyc);
    end
  endtask

  task automatic test_abort();
    int base;
    bit to;
    logic [31:0] w2;
    base = rd_ptr;
    push_word($urandom);
    w2 = $urandom;
    push_word(w2);
    push_word($urandom);
    clear_mon();
    tx_ready = 1'b1;
    start    = 1'b1;
    len      = LW'(8);
    tick();
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (got_q.size() >= 2) break;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_stop: got valid=%0d busy=%0d expected 0/0", tx_valid, busy);
    end
    repeat (3) tick();
    checks++;
    if (dones !== 0 || got_q.size() !== 2) begin
      errors++; $display("FAIL abort_no_done: got dones=%0d bytes=%0d expected 0/2", dones, got_q.size());
    end
    checks++;
    if (got_q.size() >= 2 && (got_q[0] !== ref_byte(base, 0) || got_q[1] !== ref_byte(base, 1))) begin
      errors++; $display("FAIL abort_bytes: got %h %h expected %h %h",
                         got_q[0], got_q[1], ref_byte(base, 0), ref_byte(base, 1));
    end
    clear_mon();
    run_packet(1, 0, 1'b0, 50, to);
    checks++;
    if (to || got_q.size() !== 1 || got_q[0] !== w2[31:24] || last_q[0] !== 1'b1) begin
      errors++; $display("FAIL abort_restart: got %0d bytes first=%h expected 1 byte %h with last",
                         got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h0, w2[31:24]);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit to;
    logic [12:0] outs;
    push_word($urandom);
    push_word($urandom);
    tx_ready = 1'b0;
    start    = 1'b1;
    len      = LW'(8);
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (tx_valid) break;
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    outs = {buf_rd_en, tx_valid, tx_last, busy, done, tx_data};
    checks++;
    if (outs !== 13'h0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", outs);
    end
    tick();
    reset = 1'b0;
    tick();
    base = rd_ptr;
    clear_mon();
    run_packet(4, 0, 1'b0, 50, to);
    checks++;
    if (to || got_q.size() !== 4 || got_q[0] !== ref_byte(base, 0) || got_q[3] !== ref_byte(base, 3)
        || dones !== 1) begin
      errors++; $display("FAIL reset_restart: got %0d bytes dones=%0d expected 4/1", got_q.size(), dones);
    end
  endtask

  task automatic test_random();
    int n, base, bad, nlast;
    bit to;
    for (int p = 0; p < 25; p++) begin
      n = $urandom_range(1, 23);
      base = rd_ptr;
      for (int w = 0; w < (n + 3) / 4 + int'($urandom_range(0, 1)); w++) push_word($urandom);
      clear_mon();
      run_packet(n, 2, 1'b1, 2000, to);
      bad = 0;
      nlast = 0;
      for (int i = 0; i < got_q.size(); i++) begin
        if (i >= n || got_q[i] !== ref_byte(base, i)) bad++;
        if (last_q[i]) nlast++;
      end
      checks++;
      if (to || got_q.size() !== n || bad !== 0) begin
        errors++; $display("FAIL rand%0d_bytes: got %0d bytes %0d wrong expected %0d bytes (timeout=%0d)",
                           p, got_q.size(), bad, n, to);
      end
      checks++;
      if (nlast !== 1 || (got_q.size() == n && last_q[n - 1] !== 1'b1)) begin
        errors++; $display("FAIL rand%0d_last: got %0d last flags expected 1 on byte %0d", p, nlast, n - 1);
      end
      checks++;
      if (pops !== (n + 3) / 4) begin
        errors++; $display("FAIL rand%0d_pops: got %0d expected %0d", p, pops, (n + 3) / 4);
      end
      checks++;
      if (dones !== 1 || done_cyc !== last_hs_cyc + 1) begin
        errors++; $display("FAIL rand%0d_done: got %0d at %0d expected 1 at %0d",
                           p, dones, done_cyc, last_hs_cyc + 1);
      end
      checks++;
      if (proto_err !== 0) begin
        errors++; $display("FAIL rand%0d_protocol: got %0d violations expected 0", p, proto_err);
      end
`ifdef READER_CSUM_EN
      checks++;
      if (csum !== ref_csum(base, n)) begin
        errors++; $display("FAIL rand%0d_csum: got %h expected %h", p, csum, ref_csum(base, n));
      end
`endif
      tick();
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic_len6();
    test_backpressure();
    test_latency();
    test_av_stall();
    test_len0();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/buffer_stream_reader.md
Name: buffer_stream_reader

Overview:
- Drains a 32-bit word buffer (auto-addressed FIFO with rd_en / data_out / data_av interface) and serialises a packet of a given byte length onto an 8-bit valid/ready stream toward the UDP/TCP transmit path.
- It is the read-side counterpart of the block that fills the buffer.
- Bytes are emitted MSB-first within each word.
- A done pulse marks packet completion.

Parameters:
- DATA_WIDTH, 32, buffer word width; must be a multiple of 8.
- LEN_WIDTH, 16, width of the packet byte-length field.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to send a packet; sampled in IDLE only.
- len  input  LEN_WIDTH  packet length in bytes; sampled with start.
- abort  input  1  cancels the packet in progress.
- buf_data_out  input  DATA_WIDTH  word from the buffer; valid the cycle after buf_rd_en is sampled high.
- buf_data_av  input  1  buffer holds at least one word.
- buf_rd_en  output  1  one-cycle pop request to the buffer.
- tx_data  output  8  stream byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  downstream accepts the byte when tx_valid and tx_ready are both high.
- tx_last  output  1  qualifies the final byte of the packet.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset: state IDLE; buf_rd_en, tx_valid, tx_last, busy and done are 0; tx_data is 0x00; internal counters are cleared.
- State machine: IDLE -> FETCH -> WAIT -> SHIFT -> (FETCH | DONE) -> IDLE.
- IDLE:
  - start with len != 0: latch len into remaining; go to FETCH.
  - start with len == 0: go to DONE; no bytes are emitted and no pop is issued.
  - Any start outside IDLE is ignored.
- FETCH:
  - buf_rd_en = buf_data_av; it is never asserted while buf_data_av is low.
  - When buf_rd_en is high, go to WAIT; otherwise stay in FETCH.
- WAIT:
  - Capture buf_data_out into the shift register.
  - Set word_bytes = DATA_WIDTH/8; go to SHIFT.
- SHIFT:
  - tx_valid = 1; tx_data = shift register MSB byte.
  - tx_last = (remaining == 1).
  - On handshake: shift left by 8, decrement remaining, decrement word_bytes.
  - If remaining becomes 0, go to DONE. Any unsent bytes of a partial final word are discarded; the word is already popped.
  - Else if word_bytes becomes 0, go to FETCH.
- tx_valid, tx_data and tx_last hold stable while tx_ready is low.
- DONE: done = 1 for exactly one cycle; next state IDLE.
- Latency: with buf_data_av high, start at cycle N gives buf_rd_en at N+1 and first tx_valid at N+3.
- Word boundary: with tx_ready held high, there is a 2-cycle bubble (FETCH, WAIT) between words.
- abort: in any non-IDLE state, the next state is IDLE.
  - tx_valid drops the next cycle and no done pulse is issued.
  - A pop already issued in FETCH is not undone; the buffer word is lost.
  - abort takes priority over the tx handshake in the same cycle.
- Reset asserted mid-packet forces IDLE immediately (asynchronously).
- remaining is LEN_WIDTH wide; the maximum packet length is 2^LEN_WIDTH-1 bytes, and it never wraps.

Optional Feature:
- Macro: READER_CSUM_EN.
- When defined:
  - Adds output csum [15:0] and an internal 16-bit ones'-complement accumulator. The accumulator is cleared on start.
  - Emitted bytes are paired big-endian into 16-bit terms; an odd trailing byte is padded with 0x00 in the low byte.
  - Each term is added with end-around carry.
  - csum is valid (and stable until the next start) from the cycle done pulses. The sum is not inverted.
  - abort leaves csum undefined.
- When undefined: no csum port and no accumulator logic.

Decomposition:
- Package buffer_stream_pkg holds:
  - state encoding localparams (S_IDLE, S_FETCH, S_WAIT, S_SHIFT, S_DONE);
  - BYTES_PER_WORD = DATA_WIDTH/8;
  - BYTE_CNT_W = clog2(BYTES_PER_WORD)+1.
- One natural sub-module: ones_comp_sum16, the pair-and-accumulate checksum unit. It is instantiated only under READER_CSUM_EN.

Test Plan:
- len=6, buffer holds 0xAABBCCDD and 0x11223344, tx_ready=1 -> bytes AA BB CC DD 11 22; tx_last on 22; exactly 2 buf_rd_en pulses; done one cycle after 22 is accepted; csum=0x88BB when READER_CSUM_EN is defined.
- len=4, tx_ready toggled 1,0,0,1,... -> tx_data and tx_valid hold while tx_ready=0; the sequence is still AA BB CC DD with tx_last on DD.
- buf_data_av=0 for 5 cycles after start, then 1 -> buf_rd_en stays 0 during the wait; first tx_valid occurs 2 cycles after the pop.
- len=0 start -> done pulses 1 cycle later; buf_rd_en and tx_valid never assert.
- abort asserted after the second byte of len=8 -> tx_valid low the next cycle, no done, busy=0; a following start with len=1 emits the next buffer word's MSB byte.
- reset pulsed while in SHIFT -> all outputs 0 immediately; start after reset behaves normally.
